// File: rtl/rocc_acc_bridge_pkg.sv
// Shared types and sizes for the RoCC accelerator bridge.
// Optional feature macro ROCC_TIMEOUT_EN is consumed by rocc_tag_table and rocc_acc_bridge.
package rocc_acc_bridge_pkg;

    localparam int NR_OUTSTANDING_DEFAULT = 2;
    localparam int ROCC_TAG_BITS          = $clog2(NR_OUTSTANDING_DEFAULT);
    localparam int TRANS_ID_BITS          = 3;

    localparam logic [63:0] TIMEOUT_RESULT = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0]              operand_a;
        logic [63:0]              operand_b;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    typedef struct packed {
        logic [31:0]              instr;
        logic [63:0]              rs1;
        logic [63:0]              rs2;
        logic [ROCC_TAG_BITS-1:0] tag;
    } rocc_cmd_t;

    typedef struct packed {
        logic [63:0]              data;
        logic [ROCC_TAG_BITS-1:0] tag;
    } rocc_resp_t;

endpackage

// File: rtl/rocc_acc_bridge_tag_table.sv
// Tag table mapping accelerator tags to scoreboard trans_ids, plus its response checker.
// With ROCC_TIMEOUT_EN defined, each live entry also carries a watchdog counter.
module rocc_tag_table
    import rocc_acc_bridge_pkg::*;
#(
    parameter int NR_OUTSTANDING = NR_OUTSTANDING_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc,
    input  logic [TRANS_ID_BITS-1:0] alloc_trans_id,
    output logic                     free_exists,
    output logic [ROCC_TAG_BITS-1:0] alloc_tag,
    input  logic                     discard,
    input  logic [ROCC_TAG_BITS-1:0] discard_tag,
    input  logic                     flush,
    input  logic                     resp,
    input  logic [ROCC_TAG_BITS-1:0] resp_tag,
    output logic                     resp_hit,
    output logic [TRANS_ID_BITS-1:0] resp_trans_id
`ifdef ROCC_TIMEOUT_EN
    ,
    output logic                     expire,
    output logic [ROCC_TAG_BITS-1:0] expire_tag,
    output logic [TRANS_ID_BITS-1:0] expire_trans_id,
    input  logic                     expire_ack
`endif
);

    if (NR_OUTSTANDING < 2 || NR_OUTSTANDING > (1 << ROCC_TAG_BITS) ||
        (NR_OUTSTANDING & (NR_OUTSTANDING - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("rocc_tag_table: unsupported NR_OUTSTANDING or TIMEOUT_CYCLES");
    end

    logic [NR_OUTSTANDING-1:0] valid;
    logic [NR_OUTSTANDING-1:0] flushed;
    logic [NR_OUTSTANDING-1:0] mark;
    logic [TRANS_ID_BITS-1:0]  trans_id [NR_OUTSTANDING];

    // Lowest free index wins allocation; lookup of the responding tag.
    always_comb begin
        free_exists   = 1'b0;
        alloc_tag     = '0;
        resp_hit      = 1'b0;
        resp_trans_id = '0;
        for (int i = NR_OUTSTANDING - 1; i >= 0; i--) begin
            free_exists   = free_exists | ~valid[i];
            alloc_tag     = valid[i] ? alloc_tag : ROCC_TAG_BITS'(i);
            resp_hit      = resp_hit | (resp & valid[i] & ~flushed[i] & (resp_tag == ROCC_TAG_BITS'(i)));
            resp_trans_id = (valid[i] && resp_tag == ROCC_TAG_BITS'(i)) ? trans_id[i] : resp_trans_id;
        end
    end

    // Entries to be marked flushed this cycle (pipeline flush or acknowledged timeout).
    always_comb begin
        mark = '0;
        for (int i = 0; i < NR_OUTSTANDING; i++) begin
`ifdef ROCC_TIMEOUT_EN
            mark[i] = flush | (expire_ack & (expire_tag == ROCC_TAG_BITS'(i)));
`else
            mark[i] = flush;
`endif
        end
    end

    // Entry state: freeing (discard or response) beats flush marking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= '0;
            flushed <= '0;
            for (int i = 0; i < NR_OUTSTANDING; i++) begin
                trans_id[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_OUTSTANDING; i++) begin
                if (alloc && alloc_tag == ROCC_TAG_BITS'(i)) begin
                    valid[i]    <= 1'b1;
                    flushed[i]  <= 1'b0;
                    trans_id[i] <= alloc_trans_id;
                end else if ((discard && discard_tag == ROCC_TAG_BITS'(i)) ||
                             (resp && resp_tag == ROCC_TAG_BITS'(i))) begin
                    valid[i]   <= 1'b0;
                    flushed[i] <= 1'b0;
                end else if (valid[i] && mark[i]) begin
                    flushed[i] <= 1'b1;
                end else begin
                    flushed[i] <= flushed[i];
                end
            end
        end
    end

`ifdef ROCC_TIMEOUT_EN
    // The write-back is registered, so expiry is raised one cycle early to land
    // the pulse TIMEOUT_CYCLES after the issue handshake.
    localparam logic [31:0] EXPIRE_AT = 32'(TIMEOUT_CYCLES - 2);

    logic [31:0] age [NR_OUTSTANDING];

    // Per-entry age counters, saturating at the expiry threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_OUTSTANDING; i++) begin
                age[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NR_OUTSTANDING; i++) begin
                if (alloc && alloc_tag == ROCC_TAG_BITS'(i)) begin
                    age[i] <= 32'd0;
                end else if (valid[i] && !flushed[i] && age[i] < EXPIRE_AT) begin
                    age[i] <= age[i] + 32'd1;
                end else begin
                    age[i] <= age[i];
                end
            end
        end
    end

    // Lowest expired live entry requests a timeout write-back until acknowledged.
    always_comb begin
        expire          = 1'b0;
        expire_tag      = '0;
        expire_trans_id = '0;
        for (int i = NR_OUTSTANDING - 1; i >= 0; i--) begin
            if (valid[i] && !flushed[i] && age[i] >= EXPIRE_AT) begin
                expire          = 1'b1;
                expire_tag      = ROCC_TAG_BITS'(i);
                expire_trans_id = trans_id[i];
            end else begin
                expire = expire;
            end
        end
    end
`endif

    rocc_tag_table_chk #(.NR_OUTSTANDING(NR_OUTSTANDING)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .resp     (resp),
        .resp_tag (resp_tag),
        .valid    (valid)
    );

endmodule

// Simulation checker: a response must name a currently allocated tag.
module rocc_tag_table_chk
    import rocc_acc_bridge_pkg::*;
#(
    parameter int NR_OUTSTANDING = NR_OUTSTANDING_DEFAULT
) (
    input logic                      clk,
    input logic                      rst,
    input logic                      resp,
    input logic [ROCC_TAG_BITS-1:0]  resp_tag,
    input logic [NR_OUTSTANDING-1:0] valid
);

    logic tag_known;

    // Whether the responding tag maps to a live entry.
    always_comb begin
        tag_known = 1'b0;
        for (int i = 0; i < NR_OUTSTANDING; i++) begin
            tag_known = tag_known | (valid[i] & (resp_tag == ROCC_TAG_BITS'(i)));
        end
    end

    assert property (@(posedge clk) disable iff (rst) resp |-> tag_known)
        else $error("rocc_tag_table: response for unallocated tag %0d", resp_tag);

endmodule

// File: rtl/rocc_acc_bridge.sv
// Execute-stage bridge between the RoCC issue port and a tagged valid/ready accelerator.
// Define ROCC_TIMEOUT_EN to enable per-command watchdog write-backs.
module rocc_acc_bridge
    import rocc_acc_bridge_pkg::*;
#(
    parameter int NR_OUTSTANDING = NR_OUTSTANDING_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     rocc_valid_i,
    output logic                     rocc_ready_o,
    input  fu_data_t                 fu_data_i,
    input  logic [31:0]              rocc_instr_i,
    output logic                     rocc_valid_o,
    output logic [TRANS_ID_BITS-1:0] rocc_trans_id_o,
    output logic [63:0]              rocc_result_o,
    output logic                     acc_cmd_valid_o,
    input  logic                     acc_cmd_ready_i,
    output rocc_cmd_t                acc_cmd_o,
    input  logic                     acc_resp_valid_i,
    output logic                     acc_resp_ready_o,
    input  rocc_resp_t               acc_resp_i
);

    logic                     cmd_valid;
    rocc_cmd_t                cmd;
    logic                     resp_ready;
    logic                     wb_valid;
    logic [TRANS_ID_BITS-1:0] wb_trans_id;
    logic [63:0]              wb_result;
    logic                     free_exists;
    logic [ROCC_TAG_BITS-1:0] alloc_tag;
    logic                     resp_hit;
    logic [TRANS_ID_BITS-1:0] resp_trans_id;

    logic issue;
    logic handoff;
    logic discard;
    logic resp_fire;

    // The register is empty-gated, so a handoff and a new issue never share a cycle.
    assign rocc_ready_o = ~rst_i & ~cmd_valid & free_exists & ~flush_i;
    assign issue        = rocc_valid_i & rocc_ready_o;
    assign handoff      = cmd_valid & acc_cmd_ready_i;
    assign discard      = flush_i & cmd_valid & ~acc_cmd_ready_i;
    assign resp_fire    = acc_resp_valid_i & resp_ready;

`ifdef ROCC_TIMEOUT_EN
    logic                     expire;
    logic [ROCC_TAG_BITS-1:0] expire_tag;
    logic [TRANS_ID_BITS-1:0] expire_trans_id;
    logic                     expire_ack;

    assign expire_ack = expire & ~resp_hit;
`endif

    rocc_tag_table #(
        .NR_OUTSTANDING (NR_OUTSTANDING),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tag_table (
        .clk             (clk_i),
        .rst             (rst_i),
        .alloc           (issue),
        .alloc_trans_id  (fu_data_i.trans_id),
        .free_exists     (free_exists),
        .alloc_tag       (alloc_tag),
        .discard         (discard),
        .discard_tag     (cmd.tag),
        .flush           (flush_i),
        .resp            (resp_fire),
        .resp_tag        (acc_resp_i.tag),
        .resp_hit        (resp_hit),
        .resp_trans_id   (resp_trans_id)
`ifdef ROCC_TIMEOUT_EN
        ,
        .expire          (expire),
        .expire_tag      (expire_tag),
        .expire_trans_id (expire_trans_id),
        .expire_ack      (expire_ack)
`endif
    );

    // Single-entry command register toward the accelerator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_valid <= 1'b0;
            cmd       <= '0;
        end else if (issue) begin
            cmd_valid <= 1'b1;
            cmd.instr <= rocc_instr_i;
            cmd.rs1   <= fu_data_i.operand_a;
            cmd.rs2   <= fu_data_i.operand_b;
            cmd.tag   <= alloc_tag;
        end else if (handoff || discard) begin
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= cmd_valid;
        end
    end

    // Response ready comes up on the first edge after reset and stays there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_ready <= 1'b0;
        end else begin
            resp_ready <= 1'b1;
        end
    end

    // Write-back register: a live response beats a pending timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid    <= 1'b0;
            wb_trans_id <= '0;
            wb_result   <= 64'd0;
        end else if (resp_hit) begin
            wb_valid    <= 1'b1;
            wb_trans_id <= resp_trans_id;
            wb_result   <= acc_resp_i.data;
`ifdef ROCC_TIMEOUT_EN
        end else if (expire) begin
            wb_valid    <= 1'b1;
            wb_trans_id <= expire_trans_id;
            wb_result   <= TIMEOUT_RESULT;
`endif
        end else begin
            wb_valid    <= 1'b0;
        end
    end

    assign acc_cmd_valid_o  = cmd_valid;
    assign acc_cmd_o        = cmd;
    assign acc_resp_ready_o = resp_ready;
    assign rocc_valid_o     = wb_valid;
    assign rocc_trans_id_o  = wb_trans_id;
    assign rocc_result_o    = wb_result;

endmodule

// File: tb/tb_rocc_acc_bridge.sv
// Directed self-checking bench for rocc_acc_bridge (timeout scenario only with ROCC_TIMEOUT_EN).
module tb_rocc_acc_bridge;
    import rocc_acc_bridge_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     rocc_valid;
    logic                     rocc_ready;
    fu_data_t                 fu_data;
    logic [31:0]              instr;
    logic                     wb_valid;
    logic [TRANS_ID_BITS-1:0] wb_tid;
    logic [63:0]              wb_result;
    logic                     cmd_valid;
    logic                     cmd_ready;
    rocc_cmd_t                cmd;
    logic                     resp_valid;
    logic                     resp_ready;
    rocc_resp_t               resp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rocc_acc_bridge #(.NR_OUTSTANDING(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .rocc_valid_i     (rocc_valid),
        .rocc_ready_o     (rocc_ready),
        .fu_data_i        (fu_data),
        .rocc_instr_i     (instr),
        .rocc_valid_o     (wb_valid),
        .rocc_trans_id_o  (wb_tid),
        .rocc_result_o    (wb_result),
        .acc_cmd_valid_o  (cmd_valid),
        .acc_cmd_ready_i  (cmd_ready),
        .acc_cmd_o        (cmd),
        .acc_resp_valid_i (resp_valid),
        .acc_resp_ready_o (resp_ready),
        .acc_resp_i       (resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [31:0] i_instr, input logic [63:0] a,
                               input logic [63:0] b, input logic [TRANS_ID_BITS-1:0] tid);
        rocc_valid        = 1'b1;
        instr             = i_instr;
        fu_data.operand_a = a;
        fu_data.operand_b = b;
        fu_data.trans_id  = tid;
        #1;
    endtask

    task automatic drive_resp(input logic [ROCC_TAG_BITS-1:0] tag, input logic [63:0] data);
        resp_valid = 1'b1;
        resp.tag   = tag;
        resp.data  = data;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; rocc_valid = 1'b0; fu_data = '0; instr = 32'd0;
        cmd_ready = 1'b0; resp_valid = 1'b0; resp = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rocc_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset: got %0b want 0", rocc_ready); end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid: got %0b want 0", cmd_valid); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid: got %0b want 0", wb_valid); end
        total++; if (resp_ready !== 1'b0) begin bad++; $display("FAIL rst_resp_ready_in_reset: got %0b want 0", resp_ready); end
        rst = 1'b0;
        tick();
        total++; if (resp_ready !== 1'b1) begin bad++; $display("FAIL rst_resp_ready: got %0b want 1", resp_ready); end
        total++; if (rocc_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", rocc_ready); end
        total++; if (wb_tid !== 3'd0 || wb_result !== 64'd0) begin bad++; $display("FAIL rst_wb_data: got %0d/%h want 0/0", wb_tid, wb_result); end
        total++; if (cmd !== rocc_cmd_t'(0)) begin bad++; $display("FAIL rst_cmd: got %h want 0", cmd); end
    endtask

    task automatic test_single();
        rocc_cmd_t exp;
        exp.instr = 32'h0000_200B; exp.rs1 = 64'd5; exp.rs2 = 64'd7; exp.tag = 1'b0;
        cmd_ready = 1'b1;
        drive_issue(32'h0000_200B, 64'd5, 64'd7, 3'd3);
        total++; if (rocc_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %0b want 1", rocc_ready); end
        tick(); rocc_valid = 1'b0;
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL single_cmd_valid: got %0b want 1", cmd_valid); end
        total++; if (cmd !== exp) begin bad++; $display("FAIL single_cmd: got %h want %h", cmd, exp); end
        total++; if (rocc_ready !== 1'b0) begin bad++; $display("FAIL single_ready_busy: got %0b want 0", rocc_ready); end
        tick();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL single_handoff: got %0b want 0", cmd_valid); end
        tick();
        drive_resp(1'b0, 64'd12);
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_wb_early: got %0b want 0", wb_valid); end
        tick(); resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_tid !== 3'd3 || wb_result !== 64'd12) begin
            bad++; $display("FAIL single_wb: got v=%0b id=%0d d=%0d want 1/3/12", wb_valid, wb_tid, wb_result); end
        tick();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_wb_pulse: got %0b want 0", wb_valid); end
    endtask

    task automatic test_back_pressure();
        rocc_cmd_t exp;
        exp.instr = 32'h0000_400B; exp.rs1 = 64'h11; exp.rs2 = 64'h22; exp.tag = 1'b0;
        cmd_ready = 1'b0;
        drive_issue(32'h0000_400B, 64'h11, 64'h22, 3'd4);
        tick(); rocc_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (cmd_valid !== 1'b1 || cmd !== exp) begin bad++; $display("FAIL bp_hold[%0d]: got v=%0b %h want 1 %h", i, cmd_valid, cmd, exp); end
            total++; if (rocc_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, rocc_ready); end
            tick();
        end
        cmd_ready = 1'b1;
        #1;
        total++; if (cmd_valid !== 1'b1 || cmd !== exp) begin bad++; $display("FAIL bp_last: got v=%0b %h want 1 %h", cmd_valid, cmd, exp); end
        tick();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL bp_handoff: got %0b want 0", cmd_valid); end
        drive_resp(1'b0, 64'h99);
        tick(); resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_tid !== 3'd4 || wb_result !== 64'h99) begin
            bad++; $display("FAIL bp_wb: got v=%0b id=%0d d=%h want 1/4/99", wb_valid, wb_tid, wb_result); end
    endtask

    task automatic test_full_table();
        cmd_ready = 1'b1;
        drive_issue(32'h0000_100B, 64'h1, 64'h2, 3'd1);
        tick(); rocc_valid = 1'b0;
        total++; if (cmd.tag !== 1'b0) begin bad++; $display("FAIL full_tag0: got %0d want 0", cmd.tag); end
        tick();
        total++; if (rocc_ready !== 1'b1) begin bad++; $display("FAIL full_ready_one: got %0b want 1", rocc_ready); end
        drive_issue(32'h0000_100B, 64'h3, 64'h4, 3'd2);
        tick(); rocc_valid = 1'b0;
        total++; if (cmd_valid !== 1'b1 || cmd.tag !== 1'b1) begin bad++; $display("FAIL full_tag1: got v=%0b tag=%0d want 1/1", cmd_valid, cmd.tag); end
        tick();
        total++; if (rocc_ready !== 1'b0) begin bad++; $display("FAIL full_ready_full: got %0b want 0", rocc_ready); end
        drive_resp(1'b1, 64'hA);
        drive_issue(32'h0000_100B, 64'h7, 64'h7, 3'd6);
        total++; if (rocc_ready !== 1'b0) begin bad++; $display("FAIL full_ready_same_cycle: got %0b want 0", rocc_ready); end
        tick(); resp_valid = 1'b0; rocc_valid = 1'b0;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL full_blocked_issue: got %0b want 0", cmd_valid); end
        total++; if (wb_valid !== 1'b1 || wb_tid !== 3'd2 || wb_result !== 64'hA) begin
            bad++; $display("FAIL ooo_wb_a: got v=%0b id=%0d d=%h want 1/2/a", wb_valid, wb_tid, wb_result); end
        total++; if (rocc_ready !== 1'b1) begin bad++; $display("FAIL full_ready_freed: got %0b want 1", rocc_ready); end
        drive_issue(32'h0000_100B, 64'h5, 64'h6, 3'd5);
        tick(); rocc_valid = 1'b0;
        total++; if (cmd_valid !== 1'b1 || cmd.tag !== 1'b1) begin bad++; $display("FAIL full_reuse_tag1: got v=%0b tag=%0d want 1/1", cmd_valid, cmd.tag); end
    endtask

    task automatic test_out_of_order();
        drive_resp(1'b0, 64'hB);
        tick();
        drive_resp(1'b1, 64'hC);
        total++; if (wb_valid !== 1'b1 || wb_tid !== 3'd1 || wb_result !== 64'hB) begin
            bad++; $display("FAIL ooo_wb_b: got v=%0b id=%0d d=%h want 1/1/b", wb_valid, wb_tid, wb_result); end
        tick(); resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_tid !== 3'd5 || wb_result !== 64'hC) begin
            bad++; $display("FAIL b2b_wb_c: got v=%0b id=%0d d=%h want 1/5/c", wb_valid, wb_tid, wb_result); end
        tick();
        total++; if (wb_valid !== 1'b0 || rocc_ready !== 1'b1) begin bad++; $display("FAIL ooo_idle: got wb=%0b rdy=%0b want 0/1", wb_valid, rocc_ready); end
    endtask

    task automatic test_flush();
        cmd_ready = 1'b1;
        drive_issue(32'h0000_300B, 64'h7, 64'h8, 3'd6);
        tick(); rocc_valid = 1'b0;
        total++; if (cmd.tag !== 1'b0) begin bad++; $display("FAIL flush_tag0: got %0d want 0", cmd.tag); end
        tick(); cmd_ready = 1'b0;
        drive_issue(32'h0000_300B, 64'h9, 64'hA, 3'd7);
        tick(); rocc_valid = 1'b0;
        total++; if (cmd_valid !== 1'b1 || cmd.tag !== 1'b1) begin bad++; $display("FAIL flush_pending: got v=%0b tag=%0d want 1/1", cmd_valid, cmd.tag); end
        flush = 1'b1; #1;
        total++; if (rocc_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %0b want 0", rocc_ready); end
        tick();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL flush_discard: got %0b want 0", cmd_valid); end
        drive_issue(32'h0000_300B, 64'h1, 64'h1, 3'd1);
        total++; if (rocc_ready !== 1'b0) begin bad++; $display("FAIL flush_gates_issue: got %0b want 0", rocc_ready); end
        tick(); flush = 1'b0; rocc_valid = 1'b0;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept: got %0b want 0", cmd_valid); end
        drive_resp(1'b0, 64'h55);
        total++; if (rocc_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after: got %0b want 1", rocc_ready); end
        tick(); resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped: got %0b want 0", wb_valid); end
        cmd_ready = 1'b1;
        drive_issue(32'h0000_500B, 64'h1, 64'h2, 3'd2);
        tick(); rocc_valid = 1'b0;
        total++; if (cmd_valid !== 1'b1 || cmd.tag !== 1'b0) begin bad++; $display("FAIL flush_tag0_free: got v=%0b tag=%0d want 1/0", cmd_valid, cmd.tag); end
        tick();
        drive_issue(32'h0000_500B, 64'h3, 64'h4, 3'd3);
        total++; if (rocc_ready !== 1'b1) begin bad++; $display("FAIL flush_tag1_ready: got %0b want 1", rocc_ready); end
        tick(); rocc_valid = 1'b0;
        total++; if (cmd_valid !== 1'b1 || cmd.tag !== 1'b1) begin bad++; $display("FAIL flush_tag1_free: got v=%0b tag=%0d want 1/1", cmd_valid, cmd.tag); end
        tick();
        total++; if (rocc_ready !== 1'b0) begin bad++; $display("FAIL flush_refull: got %0b want 0", rocc_ready); end
        drive_resp(1'b0, 64'h10);
        tick();
        drive_resp(1'b1, 64'h20);
        total++; if (wb_valid !== 1'b1 || wb_tid !== 3'd2 || wb_result !== 64'h10) begin
            bad++; $display("FAIL flush_wb0: got v=%0b id=%0d d=%h want 1/2/10", wb_valid, wb_tid, wb_result); end
        tick(); resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_tid !== 3'd3 || wb_result !== 64'h20) begin
            bad++; $display("FAIL flush_wb1: got v=%0b id=%0d d=%h want 1/3/20", wb_valid, wb_tid, wb_result); end
        tick();
    endtask

`ifdef ROCC_TIMEOUT_EN
    task automatic test_timeout();
        cmd_ready = 1'b1;
        drive_issue(32'h0000_600B, 64'h1, 64'h1, 3'd3);
        tick(); rocc_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL to_early[%0d]: got %0b want 0", k, wb_valid); end
            tick();
        end
        total++; if (wb_valid !== 1'b1 || wb_tid !== 3'd3 || wb_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL to_wb: got v=%0b id=%0d d=%h want 1/3/all-ones", wb_valid, wb_tid, wb_result); end
        tick();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL to_pulse: got %0b want 0", wb_valid); end
        drive_resp(1'b0, 64'h77);
        tick(); resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL to_late_dropped: got %0b want 0", wb_valid); end
        total++; if (rocc_ready !== 1'b1) begin bad++; $display("FAIL to_freed: got %0b want 1", rocc_ready); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_full_table();
        test_out_of_order();
        test_flush();
`ifdef ROCC_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
